// File: rtl/axil_mem_slave.sv
// AXI4-Lite slave RAM: independent write and read state machines sharing one clock,
// byte-strobed writes, single-beat reads, SLVERR for word indices at or beyond DEPTH.
module axil_mem_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 48
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_areset,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic                    s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic                    s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    W_IDLE,
    W_WAIT_DATA,
    W_WAIT_ADDR,
    W_COMMIT,
    W_RESP
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FETCH,
    R_RESP
  } r_state_t;

  w_state_t              w_state;
  r_state_t              r_state;
  logic [IDX_W-1:0]      wr_idx;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic aw_hs, w_hs, ar_hs;
  logic wr_in_range, rd_in_range;

  // Byte-offset bits never select anything; fold them away explicitly.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
    return {1'b0, idx} < (IDX_W + 1)'(DEPTH);
  endfunction

  assign aw_hs       = s_axi_awvalid & s_axi_awready;
  assign w_hs        = s_axi_wvalid & s_axi_wready;
  assign ar_hs       = s_axi_arvalid & s_axi_arready;
  assign wr_in_range = idx_in_range(wr_idx);
  assign rd_in_range = idx_in_range(rd_idx);

  // NOTE: all state and outputs use non-blocking assignments so every register
  // samples pre-edge values; blocking here would make order of statements matter.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= 1'b0;
      wr_idx        <= '0;
      wr_data       <= '0;
      wr_strb       <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) wr_idx <= s_axi_awaddr[ADDR_WIDTH-1:2];
          if (w_hs) begin
            wr_data <= s_axi_wdata;
            wr_strb <= s_axi_wstrb;
          end
          if (aw_hs && w_hs) begin
            w_state       <= W_COMMIT;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
          end else if (aw_hs) begin
            w_state       <= W_WAIT_DATA;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
          end else if (w_hs) begin
            w_state       <= W_WAIT_ADDR;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b0;
          end else begin
            // Also raises the readies on the first edge after reset release.
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b1;
          end
        end
        W_WAIT_DATA: begin
          if (w_hs) begin
            wr_data      <= s_axi_wdata;
            wr_strb      <= s_axi_wstrb;
            w_state      <= W_COMMIT;
            s_axi_wready <= 1'b0;
          end
        end
        W_WAIT_ADDR: begin
          if (aw_hs) begin
            wr_idx        <= s_axi_awaddr[ADDR_WIDTH-1:2];
            w_state       <= W_COMMIT;
            s_axi_awready <= 1'b0;
          end
        end
        W_COMMIT: begin
          s_axi_bvalid <= 1'b1;
          s_axi_bresp  <= ~wr_in_range;
          w_state      <= W_RESP;
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= 1'b0;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // NOTE: the RAM array has no reset; clearing it would force it into flops and
  // its contents are undefined until written anyway.
  always_ff @(posedge s_axi_aclk) begin
    if (w_state == W_COMMIT && wr_in_range) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wr_strb[b]) mem[wr_idx[MEM_AW-1:0]][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // A same-edge write to the fetched word lands after this read samples it,
  // so a colliding read returns the pre-write value.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rresp   <= 1'b0;
      s_axi_rdata   <= '0;
      rd_idx        <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            rd_idx        <= s_axi_araddr[ADDR_WIDTH-1:2];
            s_axi_arready <= 1'b0;
            r_state       <= R_FETCH;
          end else begin
            s_axi_arready <= 1'b1;
          end
        end
        R_FETCH: begin
          s_axi_rdata  <= rd_in_range ? mem[rd_idx[MEM_AW-1:0]] : '0;
          s_axi_rresp  <= ~rd_in_range;
          s_axi_rvalid <= 1'b1;
          r_state      <= R_RESP;
        end
        R_RESP: begin
          if (s_axi_rready) begin
            s_axi_rvalid  <= 1'b0;
            s_axi_arready <= 1'b1;
            r_state       <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_mem_slave.sv
// Directed bench for axil_mem_slave: a table of write/readback vectors plus
// hand-written sequences for backpressure, read/write collision and mid-transaction reset.
module tb_axil_mem_slave;

  logic        clk;
  logic        rst;
  logic [7:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bresp;
  logic        bvalid;
  logic        bready;
  logic [7:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rresp;
  logic        rvalid;
  logic        rready;

  int errors = 0;
  int checks = 0;

  axil_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(48)) dut (
    .s_axi_aclk    (clk),
    .s_axi_areset  (rst),
    .s_axi_awaddr  (awaddr),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          mode;       // 0: AW+W together, 1: AW first, 2: W first
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        exp_bresp;
    logic [7:0]  raddr;
    logic [31:0] exp_rdata;
    logic        exp_rresp;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where the chosen ready is high.
  task automatic wait_ready(input int ch, input string name);
    int n = 0;
    while (!((ch == 0) ? awready : (ch == 1) ? wready : arready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL %s: ready never rose within 20 cycles", name);
    end
  endtask

  // Entered at the negedge right after the final AW/W handshake edge N.
  task automatic finish_write(output logic resp);
    check("bvalid low at N+1", bvalid, 0);
    @(negedge clk);
    check("bvalid high at N+2", bvalid, 1);
    resp = bresp;
    bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bready = 1'b0;
    check("bvalid cleared", bvalid, 0);
    check("awready back", awready, 1);
    check("wready back", wready, 1);
  endtask

  task automatic do_write(input int mode, input logic [7:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic resp);
    awaddr = addr;
    wdata  = data;
    wstrb  = strb;
    if (mode == 0) begin
      awvalid = 1'b1;
      wvalid  = 1'b1;
      wait_ready(0, "awready");
      wait_ready(1, "wready");
      @(posedge clk);
      @(negedge clk);
      awvalid = 1'b0;
      wvalid  = 1'b0;
    end else if (mode == 1) begin
      awvalid = 1'b1;
      wait_ready(0, "awready");
      @(posedge clk);
      @(negedge clk);
      awvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
        check("awready low in WAIT_DATA", awready, 0);
        check("wready high in WAIT_DATA", wready, 1);
        @(negedge clk);
      end
      wvalid = 1'b1;
      wait_ready(1, "wready");
      @(posedge clk);
      @(negedge clk);
      wvalid = 1'b0;
    end else begin
      wvalid = 1'b1;
      wait_ready(1, "wready");
      @(posedge clk);
      @(negedge clk);
      wvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
        check("wready low in WAIT_ADDR", wready, 0);
        check("awready high in WAIT_ADDR", awready, 1);
        @(negedge clk);
      end
      awvalid = 1'b1;
      wait_ready(0, "awready");
      @(posedge clk);
      @(negedge clk);
      awvalid = 1'b0;
    end
    finish_write(resp);
  endtask

  task automatic do_read(input logic [7:0] addr, output logic [31:0] data, output logic resp);
    araddr  = addr;
    arvalid = 1'b1;
    wait_ready(2, "arready");
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    check("rvalid low at AR+1", rvalid, 0);
    @(negedge clk);
    check("rvalid high at AR+2", rvalid, 1);
    data = rdata;
    resp = rresp;
    rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rready = 1'b0;
    check("rvalid cleared", rvalid, 0);
    check("arready back", arready, 1);
  endtask

  initial begin
    logic        resp;
    logic [31:0] rd;
    logic        rr;

    vecs[0]  = '{0, 8'h10, 32'hDEADBEEF, 4'hF, 1'b0, 8'h10, 32'hDEADBEEF, 1'b0};
    vecs[1]  = '{1, 8'h20, 32'h11223344, 4'hF, 1'b0, 8'h20, 32'h11223344, 1'b0};
    vecs[2]  = '{2, 8'h24, 32'h55667788, 4'hF, 1'b0, 8'h24, 32'h55667788, 1'b0};
    vecs[3]  = '{0, 8'h08, 32'hAABBCCDD, 4'hF, 1'b0, 8'h08, 32'hAABBCCDD, 1'b0};
    vecs[4]  = '{0, 8'h08, 32'h00001122, 4'h3, 1'b0, 8'h08, 32'hAABB1122, 1'b0};
    vecs[5]  = '{0, 8'h00, 32'h12345678, 4'hF, 1'b0, 8'h00, 32'h12345678, 1'b0};
    vecs[6]  = '{1, 8'hC0, 32'hFFFFFFFF, 4'hF, 1'b1, 8'hC0, 32'h00000000, 1'b1};
    vecs[7]  = '{0, 8'h03, 32'h00000000, 4'h0, 1'b0, 8'h01, 32'h12345678, 1'b0};
    vecs[8]  = '{0, 8'hBC, 32'hCAFEF00D, 4'hF, 1'b0, 8'hBC, 32'hCAFEF00D, 1'b0};
    vecs[9]  = '{2, 8'hFC, 32'h00000000, 4'hF, 1'b1, 8'hFE, 32'h00000000, 1'b1};
    vecs[10] = '{0, 8'h0A, 32'h99887766, 4'hA, 1'b0, 8'h08, 32'h99BB7722, 1'b0};

    rst = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;

    repeat (2) @(negedge clk);
    check("reset awready", awready, 0);
    check("reset wready", wready, 0);
    check("reset arready", arready, 0);
    check("reset bvalid", bvalid, 0);
    check("reset rvalid", rvalid, 0);
    check("reset rdata", rdata, 0);
    rst = 1'b0;
    #1;
    check("arready before first edge", arready, 0);
    @(negedge clk);
    check("awready after release", awready, 1);
    check("wready after release", wready, 1);
    check("arready after release", arready, 1);

    for (int i = 0; i < 11; i++) begin
      do_write(vecs[i].mode, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, resp);
      check($sformatf("vec%0d bresp", i), resp, vecs[i].exp_bresp);
      do_read(vecs[i].raddr, rd, rr);
      check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d rresp", i), rr, vecs[i].exp_rresp);
    end

    // Write and read of the same word on the same edges, then hold both responses.
    awaddr = 8'h10; wdata = 32'h0BADCAFE; wstrb = 4'hF; araddr = 8'h10;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp bvalid held", bvalid, 1);
      check("bp bresp held", bresp, 0);
      check("bp rvalid held", rvalid, 1);
      check("bp rdata pre-write", rdata, 32'hDEADBEEF);
      check("bp awready low", awready, 0);
      check("bp arready low", arready, 0);
      @(negedge clk);
    end
    bready = 1'b1; rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    check("bp bvalid cleared", bvalid, 0);
    check("bp rvalid cleared", rvalid, 0);
    check("bp awready back", awready, 1);
    check("bp arready back", arready, 1);
    do_read(8'h10, rd, rr);
    check("collision post-write rdata", rd, 32'h0BADCAFE);

    // Reset with the write in W_WAIT_DATA and the read in R_RESP.
    awaddr = 8'h14; araddr = 8'h10;
    awvalid = 1'b1; arvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    check("pre-reset rvalid", rvalid, 1);
    check("pre-reset awready", awready, 0);
    check("pre-reset wready", wready, 1);
    #2 rst = 1'b1;
    #1;
    check("async rvalid drop", rvalid, 0);
    check("async bvalid drop", bvalid, 0);
    check("async wready drop", wready, 0);
    check("async arready drop", arready, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post-reset awready", awready, 1);
    check("post-reset wready", wready, 1);
    check("post-reset arready", arready, 1);
    for (int i = 0; i < 3; i++) begin
      check("no stale bvalid", bvalid, 0);
      check("no stale rvalid", rvalid, 0);
      @(negedge clk);
    end
    do_write(0, 8'h14, 32'h600DF00D, 4'hF, resp);
    check("post-reset bresp", resp, 0);
    do_read(8'h14, rd, rr);
    check("post-reset rdata", rd, 32'h600DF00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
